// File: rtl/arg_entry_ctrl_pkg.sv
// Shared types and default sizing for the ALU virtual board input side.
// Optional feature macro used by arg_entry_ctrl: ARG_AUTO_ADVANCE_EN.
package alu_board_pkg;

  localparam int OPERAND_DESIGN_DEF  = 3;
  localparam int RESULT_DESIGN_DEF   = 7;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  // Bit 1 selects the operand (A/B), bit 0 selects the nibble (lo/hi).
  localparam logic [1:0] POS_A_LO = 2'b00;
  localparam logic [1:0] POS_A_HI = 2'b01;
  localparam logic [1:0] POS_B_LO = 2'b10;
  localparam logic [1:0] POS_B_HI = 2'b11;

  typedef enum logic [1:0] {
    A_LO = POS_A_LO,
    A_HI = POS_A_HI,
    B_LO = POS_B_LO,
    B_HI = POS_B_HI
  } entry_pos_t;

  function automatic entry_pos_t next_slot(input entry_pos_t pos);
    entry_pos_t nxt;
    case (pos)
      A_LO:    nxt = A_HI;
      A_HI:    nxt = B_LO;
      B_LO:    nxt = B_HI;
      B_HI:    nxt = A_LO;
      default: nxt = A_LO;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/arg_entry_ctrl_if.sv
// Key/switch inputs and display/operand outputs of the argument entry controller.
// The master side is the board (keys, switches, consumers); the slave side is the controller.
interface arg_entry_ctrl_if
  import alu_board_pkg::*;
#(
  parameter int OPERAND_DESIGN = OPERAND_DESIGN_DEF,
  parameter int RESULT_DESIGN  = RESULT_DESIGN_DEF
);

  logic [OPERAND_DESIGN:0] sw_arg;
  logic                    key_select_n;
  logic                    key_lohi_n;
  logic                    key_load_n;
  logic [OPERAND_DESIGN:0] arg;
  logic                    select_args;
  logic                    lo_hi_arg;
  logic                    load_args;
  logic [RESULT_DESIGN:0]  operand_a;
  logic [RESULT_DESIGN:0]  operand_b;

  modport master (
    output sw_arg, key_select_n, key_lohi_n, key_load_n,
    input  arg, select_args, lo_hi_arg, load_args, operand_a, operand_b
  );

  modport slave (
    input  sw_arg, key_select_n, key_lohi_n, key_load_n,
    output arg, select_args, lo_hi_arg, load_args, operand_a, operand_b
  );

endinterface

// File: rtl/arg_entry_ctrl_key_debounce.sv
// One push key: two-flop synchronizer, stability counter and registered press event.
// The press pulse is high for one cycle per accepted 0->1 debounced transition.
module key_debounce
  import alu_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_r;
  logic             deb_d_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  // Bring the raw key into the clock domain, inverted so 1 means pressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= ~key_n;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      deb_r <= 1'b0;
    end else if (sync2_r == deb_r) begin
      cnt_r <= '0;
      deb_r <= deb_r;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
      deb_r <= sync2_r;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      deb_r <= deb_r;
    end
  end

  // Rising edge of the debounced level becomes a single-cycle press event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_d_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      deb_d_r <= deb_r;
      press_r <= deb_r & ~deb_d_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/arg_entry_ctrl.sv
// Argument entry controller: debounced keys step a nibble position and load switch values.
// ARG_AUTO_ADVANCE_EN: advance the position after each load and drop toggles coinciding with a load.
module arg_entry_ctrl
  import alu_board_pkg::*;
#(
  parameter int OPERAND_DESIGN  = OPERAND_DESIGN_DEF,
  parameter int RESULT_DESIGN   = RESULT_DESIGN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic            clk,
  input logic            rst,
  arg_entry_ctrl_if.slave bus
);

  localparam int NIB_W = OPERAND_DESIGN + 1;

  logic [OPERAND_DESIGN:0] sw_meta_r;
  logic [OPERAND_DESIGN:0] arg_r;
  logic                    sel_ev_s;
  logic                    lohi_ev_s;
  logic                    load_ev_s;
  entry_pos_t              pos_r;
  entry_pos_t              pos_nxt_s;
  logic [RESULT_DESIGN:0]  op_a_r;
  logic [RESULT_DESIGN:0]  op_b_r;
  logic [RESULT_DESIGN:0]  op_a_nxt_s;
  logic [RESULT_DESIGN:0]  op_b_nxt_s;
  logic                    load_args_r;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_select (
    .clk   (clk),
    .rst   (rst),
    .key_n (bus.key_select_n),
    .press (sel_ev_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_lohi (
    .clk   (clk),
    .rst   (rst),
    .key_n (bus.key_lohi_n),
    .press (lohi_ev_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_load (
    .clk   (clk),
    .rst   (rst),
    .key_n (bus.key_load_n),
    .press (load_ev_s)
  );

  // Two-flop synchronizer for the argument switches; the second flop is the visible arg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_r <= '0;
      arg_r     <= '0;
    end else begin
      sw_meta_r <= bus.sw_arg;
      arg_r     <= sw_meta_r;
    end
  end

  // Next entry position; select flips the operand bit, lo/hi flips the nibble bit.
  always_comb begin
    pos_nxt_s = pos_r;
`ifdef ARG_AUTO_ADVANCE_EN
    if (load_ev_s) begin
      pos_nxt_s = next_slot(pos_r);
    end else begin
      pos_nxt_s = entry_pos_t'({pos_r[1] ^ sel_ev_s, pos_r[0] ^ lohi_ev_s});
    end
`else
    pos_nxt_s = entry_pos_t'({pos_r[1] ^ sel_ev_s, pos_r[0] ^ lohi_ev_s});
`endif
  end

  // Load writes at the position held before this edge's toggles take effect.
  always_comb begin
    op_a_nxt_s = op_a_r;
    op_b_nxt_s = op_b_r;
    if (load_ev_s) begin
      case (pos_r)
        A_LO:    op_a_nxt_s[OPERAND_DESIGN:0]      = arg_r;
        A_HI:    op_a_nxt_s[RESULT_DESIGN:NIB_W]   = arg_r;
        B_LO:    op_b_nxt_s[OPERAND_DESIGN:0]      = arg_r;
        B_HI:    op_b_nxt_s[RESULT_DESIGN:NIB_W]   = arg_r;
        default: begin
          op_a_nxt_s = op_a_r;
          op_b_nxt_s = op_b_r;
        end
      endcase
    end else begin
      op_a_nxt_s = op_a_r;
      op_b_nxt_s = op_b_r;
    end
  end

  // Position, operand and load-strobe registers share one edge so load_args marks new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_r       <= A_LO;
      op_a_r      <= '0;
      op_b_r      <= '0;
      load_args_r <= 1'b0;
    end else begin
      pos_r       <= pos_nxt_s;
      op_a_r      <= op_a_nxt_s;
      op_b_r      <= op_b_nxt_s;
      load_args_r <= load_ev_s;
    end
  end

  assign bus.arg         = arg_r;
  assign bus.select_args = pos_r[1];
  assign bus.lo_hi_arg   = pos_r[0];
  assign bus.load_args   = load_args_r;
  assign bus.operand_a   = op_a_r;
  assign bus.operand_b   = op_b_r;

endmodule

// File: doc/arg_entry_ctrl.md
# arg_entry_ctrl

- Input-side controller for the ALU virtual board.
- Synchronizes and debounces three push keys and synchronizes the argument switches.
- Steps an entry position over four nibble slots (A-lo, A-hi, B-lo, B-hi) and writes the switch nibble into operand A or B on a load press.
- Its outputs drive the seven-segment driver (`arg`, `select_args`, `lo_hi_arg`, `load_args`, operands) and the ALU operand inputs.

## Interface
- `OPERAND_DESIGN`, default 3: MSB index of the switch argument (nibble).
- `RESULT_DESIGN`, default 7: MSB index of each operand; must equal 2*OPERAND_DESIGN+1.
- `DEBOUNCE_CYCLES`, default 500000: stable cycles required before a key level is accepted (10 ms at 50 MHz); minimum 2.
- `clk` in 1: single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `sw_arg` in OPERAND_DESIGN+1: raw argument switches, asynchronous.
- `key_select_n` in 1: raw key, active-low; toggles operand select.
- `key_lohi_n` in 1: raw key, active-low; toggles nibble select.
- `key_load_n` in 1: raw key, active-low; writes `arg` at the current position.
- `arg` out OPERAND_DESIGN+1: synchronized switch value.
- `select_args` out 1: 0 = operand A, 1 = operand B.
- `lo_hi_arg` out 1: 0 = low nibble, 1 = high nibble.
- `load_args` out 1: one-cycle pulse, coincident with an operand update.
- `operand_a` out RESULT_DESIGN+1: operand A register.
- `operand_b` out RESULT_DESIGN+1: operand B register.

## Operation
- Reset values: `arg`=0, `select_args`=0, `lo_hi_arg`=0, `load_args`=0, `operand_a`=0, `operand_b`=0.
- Debounced key state resets to released; debounce counters reset to 0.
- Reset mid-debounce or mid-pulse discards all pending events.
- Switches: two-flop synchronizer; `arg` is the second flop.
- Each key: two-flop synchronizer, inverted to active-high.
  - Counter increments while the synchronized level differs from the debounced level.
  - Counter clears when the levels are equal.
  - When the count reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - A debounced 0->1 transition produces a registered one-cycle press event. Release produces no event.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
  - Holding a key produces exactly one event.
- Entry position state (`entry_pos_t`): A_LO, A_HI, B_LO, B_HI. `select_args` and `lo_hi_arg` are decoded from it.
- Select event: toggles A/B and keeps the nibble.
- Lo/hi event: toggles the nibble and keeps the operand.
- Load event, at the next edge:
  - The nibble at the current position is replaced with `arg`; the other nibble and the other operand are unchanged.
  - `load_args` is high for that same single cycle.
- Simultaneous events in one cycle:
  - The load writes using the position before any toggle.
  - Select and lo/hi toggles both apply in the same edge.
- Back-to-back loads at the same position: last value wins; each load gives its own `load_args` pulse.

## Timing
- Key press latency: with the raw key low and stable, the event pulse is high DEBOUNCE_CYCLES+3 edges after the first edge that samples the low level.
  - 2 cycles synchronizer, DEBOUNCE_CYCLES counting, 1 cycle edge register.
- Position change and operand write appear one edge after the event pulse.
- `load_args` aligns with the first cycle in which the new operand value is visible.
- `arg` lags `sw_arg` by 2 edges.
- No output has a combinational path from an input.

## Configuration
- `ARG_AUTO_ADVANCE_EN` defined:
  - After each load, the position advances A_LO->A_HI->B_LO->B_HI->A_LO at the same edge as the write.
  - Select and lo/hi events arriving in the same cycle as a load are dropped.
  - Events in other cycles toggle as normal.
- `ARG_AUTO_ADVANCE_EN` undefined: position changes only on select and lo/hi events.

## Structure
- Package `alu_board_pkg` holds:
  - `entry_pos_t` enum;
  - default width constants for OPERAND_DESIGN/RESULT_DESIGN;
  - `DEBOUNCE_CYCLES` default.
- Sub-module `key_debounce` (sync + counter + rise-event register, parameter DEBOUNCE_CYCLES), instantiated three times.
- Top level holds the switch synchronizer, position FSM and operand registers.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4.
- Reset: assert `rst` asynchronously mid-cycle.
  - -> All outputs 0 immediately; position A_LO.
- Bounce: `key_load_n` low for 3 cycles then high, repeated 5 times.
  - -> No `load_args` pulse; operands unchanged.
- Load A_LO: `sw_arg`=4'hA, press load and hold 20 cycles.
  - -> Exactly one `load_args` pulse, 8 edges after the first low sample (7 to the press event, 1 to the write); `operand_a`=8'h0A.
- Position entry (auto-advance off): press lo/hi, load `sw_arg`=4'h5; press select, load 4'h3.
  - -> `operand_a`=8'h5A, `operand_b`=8'h30, `select_args`=1, `lo_hi_arg`=1.
- Simultaneous events: select and load pressed together at A_LO with `sw_arg`=4'hF.
  - -> `operand_a`=8'h0F, `operand_b` unchanged, `select_args`=1.
- `ARG_AUTO_ADVANCE_EN`: four loads of 1, 2, 3, 4 from reset.
  - -> `operand_a`=8'h21, `operand_b`=8'h43, position back to A_LO.
